// File: rtl/seven_seg_pkg.sv
// Shared types and the hex-to-segment table for the 7-segment scan driver.
// Segment bit order is {g,f,e,d,c,b,a}, active-high (lit = 1) inside the design.
package seven_seg_pkg;

   localparam int unsigned SEG_W = 7;

   typedef logic [SEG_W-1:0] seg_t;

   localparam seg_t SEG_OFF = 7'h00;

   // Hex glyphs 0-9, A, b, C, d, E, F.
   function automatic seg_t hex_to_seg(input logic [3:0] nib);
      seg_t s;
      case (nib)
         4'h0:    s = 7'h3F;
         4'h1:    s = 7'h06;
         4'h2:    s = 7'h5B;
         4'h3:    s = 7'h4F;
         4'h4:    s = 7'h66;
         4'h5:    s = 7'h6D;
         4'h6:    s = 7'h7D;
         4'h7:    s = 7'h07;
         4'h8:    s = 7'h7F;
         4'h9:    s = 7'h6F;
         4'hA:    s = 7'h77;
         4'hB:    s = 7'h7C;
         4'hC:    s = 7'h39;
         4'hD:    s = 7'h5E;
         4'hE:    s = 7'h79;
         4'hF:    s = 7'h71;
         default: s = SEG_OFF;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/seven_seg_hex_decode.sv
// Combinational nibble -> active-high segment pattern.
//   nibble_i : hex value 0-F
//   seg_o    : {g,f,e,d,c,b,a}, 1 = lit
module seven_seg_hex_decode
   import seven_seg_pkg::*;
(
   input  logic [3:0] nibble_i,
   output seg_t       seg_o
);

   assign seg_o = hex_to_seg(nibble_i);

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed driver for NUM_DIGITS 7-segment digits with double-buffered data,
// per-digit blanking and one dead cycle at the start of every slot to avoid ghosting.
// All outputs are registered (one cycle behind the prescaler/index state).
//   clk        : system clock, rising edge
//   rst_n      : asynchronous reset, active low
//   load       : 1-cycle strobe capturing digits_in/blank_in into the shadow buffer
//   digits_in  : nibble k = hex value of digit k
//   blank_in   : bit k = 1 blanks digit k
//   dim_duty   : (only with SEVEN_SEG_DIM_EN) dig_en asserted while pwm count <= dim_duty
//   seg        : {g,f,e,d,c,b,a} at pin polarity
//   dig_en     : one-hot digit select at pin polarity
//   frame_done : 1-cycle pulse after the last slot of a frame ends
// Optional feature macro: SEVEN_SEG_DIM_EN (PWM dimming of dig_en).
module seven_seg_scan_driver
   import seven_seg_pkg::*;
#(
   parameter int unsigned NUM_DIGITS     = 4,
   parameter int unsigned CLK_DIV        = 1000,
   parameter bit          ACTIVE_LOW_SEG = 1'b0,
   parameter bit          ACTIVE_LOW_DIG = 1'b1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] digits_in,
   input  logic [NUM_DIGITS-1:0]   blank_in,
`ifdef SEVEN_SEG_DIM_EN
   input  logic [2:0]              dim_duty,
`endif
   output logic [SEG_W-1:0]        seg,
   output logic [NUM_DIGITS-1:0]   dig_en,
   output logic                    frame_done
);

   localparam int unsigned PreW = $clog2(CLK_DIV);
   localparam int unsigned IdxW = $clog2(NUM_DIGITS);
   localparam logic [PreW-1:0] PreLast = PreW'(CLK_DIV - 1);
   localparam logic [IdxW-1:0] IdxLast = IdxW'(NUM_DIGITS - 1);
   localparam seg_t SegPinMask = {SEG_W{ACTIVE_LOW_SEG}};
   localparam logic [NUM_DIGITS-1:0] DigPinMask = {NUM_DIGITS{ACTIVE_LOW_DIG}};

   logic [PreW-1:0] presc_q, presc_d;
   logic [IdxW-1:0] idx_q, idx_d;
   logic [NUM_DIGITS-1:0][3:0] shadow_q, shadow_d, active_q, active_d;
   logic [NUM_DIGITS-1:0] shadow_blank_q, shadow_blank_d, active_blank_q, active_blank_d;
   logic pending_q, pending_d;
   seg_t seg_q, seg_d;
   logic [NUM_DIGITS-1:0] dig_q, dig_d;
   logic frame_done_q;

   logic slot_end, frame_end, slot_live, dig_gate;
   logic [3:0] cur_nibble;
   seg_t dec_seg;
   logic [NUM_DIGITS-1:0] dig_sel;

`ifdef SEVEN_SEG_DIM_EN
   logic [2:0] pwm_q;
   assign dig_gate = (pwm_q <= dim_duty);
`else
   assign dig_gate = 1'b1;
`endif

   assign cur_nibble = active_q[idx_q];

   seven_seg_hex_decode u_hex_decode (
      .nibble_i (cur_nibble),
      .seg_o    (dec_seg)
   );

   always_comb begin
      slot_end  = (presc_q == PreLast);
      frame_end = slot_end && (idx_q == IdxLast);
      presc_d   = slot_end ? '0 : presc_q + 1'b1;
      idx_d     = idx_q;
      if (slot_end) begin
         idx_d = (idx_q == IdxLast) ? '0 : idx_q + 1'b1;
      end

      shadow_d       = shadow_q;
      shadow_blank_d = shadow_blank_q;
      active_d       = active_q;
      active_blank_d = active_blank_q;
      pending_d      = pending_q;
      if (load && frame_end) begin
         // Load on the boundary bypasses the shadow wait and lands directly in active.
         shadow_d       = digits_in;
         shadow_blank_d = blank_in;
         active_d       = digits_in;
         active_blank_d = blank_in;
         pending_d      = 1'b0;
      end else if (load) begin
         shadow_d       = digits_in;
         shadow_blank_d = blank_in;
         pending_d      = 1'b1;
      end else if (frame_end && pending_q) begin
         active_d       = shadow_q;
         active_blank_d = shadow_blank_q;
         pending_d      = 1'b0;
      end

      // Prescaler 0 is the dead cycle: everything dark while the digit select changes.
      slot_live = (presc_q != '0);
      dig_sel   = '0;
      dig_sel[idx_q] = 1'b1;
      seg_d = (slot_live && !active_blank_q[idx_q]) ? dec_seg : SEG_OFF;
      dig_d = (slot_live && dig_gate) ? dig_sel : '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc_q        <= '0;
         idx_q          <= '0;
         shadow_q       <= '0;
         active_q       <= '0;
         shadow_blank_q <= '1;
         active_blank_q <= '1;
         pending_q      <= 1'b0;
         seg_q          <= SEG_OFF ^ SegPinMask;
         dig_q          <= DigPinMask;
         frame_done_q   <= 1'b0;
      end else begin
         presc_q        <= presc_d;
         idx_q          <= idx_d;
         shadow_q       <= shadow_d;
         active_q       <= active_d;
         shadow_blank_q <= shadow_blank_d;
         active_blank_q <= active_blank_d;
         pending_q      <= pending_d;
         seg_q          <= seg_d ^ SegPinMask;
         dig_q          <= dig_d ^ DigPinMask;
         frame_done_q   <= frame_end;
      end
   end

`ifdef SEVEN_SEG_DIM_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pwm_q <= '0;
      end else begin
         pwm_q <= pwm_q + 3'd1;
      end
   end
`endif

   assign seg        = seg_q;
   assign dig_en     = dig_q;
   assign frame_done = frame_done_q;

endmodule
